pingpong_stream_buf: RTL and testbench

- Parametrised two-bank ping-pong frame buffer with internal storage and valid/ready/last streaming on both sides.
- Sits between a bursty upstream producer and a downstream consumer.
- Absorbs one full frame while the previous frame drains.
- Frames of 1..DEPTH beats; a frame ends on s_last or when a bank fills.

---
 rtl/ppb_pkg.sv | 14 +
 rtl/ppb_bank_ram.sv | 26 ++
 rtl/pingpong_stream_buf.sv | 140 ++++++++++++++
 tb/tb_pingpong_stream_buf.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppb_pkg.sv
// Shared types and constants for the ping-pong stream buffer.
package ppb_pkg;

  localparam int STATUS_W   = 16;
  localparam int SKID_DEPTH = 2;

  typedef logic bank_t;

  // Frame length must represent DEPTH itself, hence one bit beyond the address.
  function automatic int ppb_len_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ppb_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port, registered read port.
module ppb_bank_ram #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_stream_buf.sv
// Two-bank ping-pong frame buffer with a 2-entry fall-through skid FIFO on the output.
// Define PPB_STATUS_CNT_EN to build the frame/stall status counters.
module pingpong_stream_buf
  import ppb_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LEN_W  = ppb_len_w(DEPTH)
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_last,
  output logic                s_ready,
  output logic                m_valid,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_last,
  input  logic                m_ready,
  output logic [1:0]          o_bank_full,
  output logic [STATUS_W-1:0] o_frame_cnt,
  output logic [STATUS_W-1:0] o_stall_cnt
);

  bank_t             wbank_q, rbank_q, rd_bank_q;
  logic [ADDR_W-1:0] waddr_q, raddr_q;
  logic [1:0]        bank_full_q;
  logic [LEN_W-1:0]  len_q [2];
  logic              rd_valid_q, rd_last_q;
  logic [DATA_W-1:0] rd_data [2];

  logic [DATA_W:0]   skid_q [SKID_DEPTH];
  logic              skid_wptr_q, skid_rptr_q;
  logic [1:0]        skid_cnt_q, skid_cnt_d;

  logic              wr_fire, wr_end, rd_issue, rd_end, slots_free;
  logic              push, fifo_pop;
  logic [DATA_W:0]   rd_beat, head;

  assign s_ready    = !rst && !bank_full_q[wbank_q];
  assign wr_fire    = s_valid && s_ready;
  assign wr_end     = s_last || (waddr_q == ADDR_W'(DEPTH - 1));
  assign slots_free = ({1'b0, skid_cnt_q} + {2'b00, rd_valid_q}) < 3'(SKID_DEPTH);
  assign rd_issue   = bank_full_q[rbank_q] && slots_free;
  assign rd_end     = ({1'b0, raddr_q} == (len_q[rbank_q] - LEN_W'(1)));

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    ppb_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
      .clk_i   (clk_50m),
      .we_i    (wr_fire && (wbank_q == bank_t'(gi))),
      .waddr_i (waddr_q),
      .wdata_i (s_data),
      .re_i    (rd_issue && (rbank_q == bank_t'(gi))),
      .raddr_i (raddr_q),
      .rdata_o (rd_data[gi])
    );
  end

  // An empty skid FIFO lets the RAM result fall straight through to the output.
  assign rd_beat    = {rd_last_q, rd_data[rd_bank_q]};
  assign head       = (skid_cnt_q != 2'd0) ? skid_q[skid_rptr_q] : rd_beat;
  assign m_valid    = (skid_cnt_q != 2'd0) || rd_valid_q;
  assign m_data     = m_valid ? head[DATA_W-1:0] : '0;
  assign m_last     = m_valid && head[DATA_W];
  assign fifo_pop   = m_ready && (skid_cnt_q != 2'd0);
  assign push       = rd_valid_q && !((skid_cnt_q == 2'd0) && m_ready);
  assign skid_cnt_d = skid_cnt_q + {1'b0, push} - {1'b0, fifo_pop};
  assign o_bank_full = bank_full_q;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      wbank_q     <= '0;
      rbank_q     <= '0;
      rd_bank_q   <= '0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      bank_full_q <= '0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      skid_wptr_q <= 1'b0;
      skid_rptr_q <= 1'b0;
      skid_cnt_q  <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_end) begin
          len_q[wbank_q]       <= {1'b0, waddr_q} + LEN_W'(1);
          bank_full_q[wbank_q] <= 1'b1;
          wbank_q              <= ~wbank_q;
          waddr_q              <= '0;
        end else begin
          waddr_q <= waddr_q + ADDR_W'(1);
        end
      end
      // The write bank is never full while writing, so these two updates hit different banks.
      rd_valid_q <= rd_issue;
      if (rd_issue) begin
        rd_bank_q <= rbank_q;
        rd_last_q <= rd_end;
        if (rd_end) begin
          bank_full_q[rbank_q] <= 1'b0;
          rbank_q              <= ~rbank_q;
          raddr_q              <= '0;
        end else begin
          raddr_q <= raddr_q + ADDR_W'(1);
        end
      end
      if (push)     skid_wptr_q <= ~skid_wptr_q;
      if (fifo_pop) skid_rptr_q <= ~skid_rptr_q;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (push) skid_q[skid_wptr_q] <= rd_beat;
  end

`ifdef PPB_STATUS_CNT_EN
  logic [STATUS_W-1:0] frame_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (m_valid && m_ready && m_last) frame_cnt_q <= frame_cnt_q + STATUS_W'(1);
      if (s_valid && !s_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + STATUS_W'(1);
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_frame_cnt = '0;
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pingpong_stream_buf.sv
// Randomized self-checking bench for pingpong_stream_buf: a beat scoreboard
// derived from the framing rules, plus directed boundary scenarios.
`timescale 1ns/1ps
module tb_pingpong_stream_buf;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 64;

  logic              clk_50m = 1'b0;
  logic              rst     = 1'b1;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data  = '0;
  logic              s_last  = 1'b0;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready = 1'b0;
  logic [1:0]        o_bank_full;
  logic [15:0]       o_frame_cnt;
  logic [15:0]       o_stall_cnt;

  always #10 clk_50m = ~clk_50m;

  pingpong_stream_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_50m     (clk_50m),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .o_bank_full (o_bank_full),
    .o_frame_cnt (o_frame_cnt),
    .o_stall_cnt (o_stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: every accepted beat is expected out in order; a frame ends
  // on s_last or on its DEPTH-th beat.
  logic [DATA_W:0] exp_q [$];
  logic [DATA_W:0] e_beat;
  logic [DATA_W:0] held;
  logic            held_v = 1'b0;
  logic            exp_last;
  int olen_q [$];
  int in_beat = 0, out_run = 0, acc_cnt = 0;
  int model_frames = 0, model_stalls = 0, ready_drops = 0;
  int cyc = 0, lat_in_cyc = -1, lat_out_cyc = -1;
  bit lat_arm = 0, watch_ready = 0;
  int mr_mode = 0;

  always @(posedge clk_50m) cyc <= cyc + 1;

  always @(negedge clk_50m) begin
    if (rst) begin
      exp_q.delete();
      in_beat = 0; out_run = 0; acc_cnt = 0;
      model_frames = 0; model_stalls = 0; held_v = 1'b0;
    end else begin
      if (held_v) begin
        check_eq("hold_valid", m_valid, 1);
        check_eq("hold_beat", {m_last, m_data}, held);
      end
      held_v = m_valid && !m_ready;
      held   = {m_last, m_data};
      if (s_valid && !s_ready) begin
        model_stalls++;
        if (watch_ready) ready_drops++;
      end
      if (s_valid && s_ready) begin
        exp_last = s_last || (in_beat == DEPTH - 1);
        exp_q.push_back({exp_last, s_data});
        in_beat = exp_last ? 0 : in_beat + 1;
        acc_cnt++;
        if (lat_arm && exp_last && lat_in_cyc < 0) lat_in_cyc = cyc;
      end
      if (m_valid && m_ready) begin
        $display("OUT cyc=%0d data=%h last=%0b", cyc, m_data, m_last);
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 1, 0);
        end else begin
          e_beat = exp_q.pop_front();
          check_eq("out_data", m_data, e_beat[DATA_W-1:0]);
          check_eq("out_last", m_last, e_beat[DATA_W]);
        end
        out_run++;
        if (m_last) begin
          olen_q.push_back(out_run);
          out_run = 0;
          model_frames++;
        end
        if (lat_arm && lat_out_cyc < 0) lat_out_cyc = cyc;
      end
    end
  end

  // Downstream ready pattern: 0 idle, 1 always, 2 random, 3 alternating.
  initial begin
    forever begin
      @(posedge clk_50m); #1;
      case (mr_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = !m_ready;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "simulation time limit");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50m); #1;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    int n = 0;
    logic acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!acc && n < 4000) begin
      @(negedge clk_50m); acc = s_ready;
      @(posedge clk_50m); #1;
      n++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!acc) check_eq("send_timeout", 0, 1);
  endtask

  task automatic send_frame(input int len, input bit with_last, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick(1);
      send_beat({$urandom, $urandom}, with_last && (i == len - 1));
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
      tick(1);
      n++;
    end
    check_eq("drain_left", exp_q.size(), 0);
    check_eq("drain_bank_full", o_bank_full, 2'b00);
  endtask

  task automatic pulse_reset();
    tick(1);
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    #1;
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_bank_full", o_bank_full, 0);
    check_eq("rst_s_ready", s_ready, 0);
    tick(2);
    rst = 1'b0;
    @(negedge clk_50m);
    check_eq("post_rst_s_ready", s_ready, 1);
    tick(1);
  endtask

  initial begin
    int n;
    // Reset state
    tick(3);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_last", m_last, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_bank_full", o_bank_full, 0);
    check_eq("rst_frame_cnt", o_frame_cnt, 0);
    check_eq("rst_stall_cnt", o_stall_cnt, 0);
    rst = 1'b0;
    @(negedge clk_50m);
    check_eq("post_rst_s_ready", s_ready, 1);
    tick(1);

    // Full-rate streaming: two 64-beat frames, last on the DEPTH-th beat
    mr_mode = 1; tick(2);
    olen_q.delete(); lat_arm = 1; watch_ready = 1;
    for (int i = 0; i < 128; i++) send_beat(64'(i), (i == 63) || (i == 127));
    wait_drain();
    lat_arm = 0; watch_ready = 0;
    check_eq("latency", lat_out_cyc - lat_in_cyc, 2);
    check_eq("ready_drops", ready_drops, 0);
    check_eq("stream_frames", olen_q.size(), 2);
    if (olen_q.size() == 2) begin
      check_eq("stream_len0", olen_q[0], 64);
      check_eq("stream_len1", olen_q[1], 64);
    end

    // 6-beat frame then a 64-beat frame closed by bank fill
    mr_mode = 0; tick(2);
    olen_q.delete();
    send_frame(6, 1, 1);
    send_frame(64, 0, 1);
    tick(3);
    check_eq("two_banks_full", o_bank_full, 2'b11);
    mr_mode = 2;
    wait_drain();
    check_eq("short_frames", olen_q.size(), 2);
    if (olen_q.size() == 2) begin
      check_eq("short_len0", olen_q[0], 6);
      check_eq("short_len1", olen_q[1], 64);
    end

    // Three frames offered against a stalled consumer
    pulse_reset();
    mr_mode = 0; tick(2);
    olen_q.delete();
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(64, 1, 0);
      end
      begin
        n = 0;
        while (acc_cnt < 128 && n < 2000) begin tick(1); n++; end
        tick(4);
        check_eq("stall_s_ready", s_ready, 0);
        check_eq("stall_bank_full", o_bank_full, 2'b11);
        mr_mode = 3;
      end
    join
    wait_drain();
    check_eq("stall_frames", olen_q.size(), 3);
    foreach (olen_q[i]) check_eq("stall_len", olen_q[i], 64);
`ifdef PPB_STATUS_CNT_EN
    check_eq("frame_cnt", o_frame_cnt, 3);
    check_eq("stall_cnt", o_stall_cnt, 64'(model_stalls));
`else
    check_eq("frame_cnt", o_frame_cnt, 0);
    check_eq("stall_cnt", o_stall_cnt, 0);
`endif

    // Ten back-to-back single-beat frames
    mr_mode = 2;
    olen_q.delete();
    for (int i = 0; i < 10; i++) send_frame(1, 1, 0);
    wait_drain();
    check_eq("single_frames", olen_q.size(), 10);
    foreach (olen_q[i]) check_eq("single_len", olen_q[i], 1);

    // Reset 30 beats into a frame while a full frame waits on the output
    mr_mode = 0; tick(2);
    send_frame(64, 1, 0);
    send_frame(30, 0, 0);
    tick(2);
    check_eq("pre_rst_m_valid", m_valid, 1);
    pulse_reset();
    mr_mode = 1;
    olen_q.delete();
    send_frame(8, 1, 0);
    wait_drain();
    check_eq("after_rst_frames", olen_q.size(), 1);
    if (olen_q.size() == 1) check_eq("after_rst_len", olen_q[0], 8);

    // Random soak: random lengths, gaps and backpressure
    mr_mode = 2;
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, DEPTH);
      send_frame(n, (n < DEPTH) || ($urandom_range(0, 1) == 1), 1);
    end
    wait_drain();
`ifdef PPB_STATUS_CNT_EN
    check_eq("final_frame_cnt", o_frame_cnt, 64'(model_frames));
    check_eq("final_stall_cnt", o_stall_cnt, 64'(model_stalls));
`else
    check_eq("final_frame_cnt", o_frame_cnt, 0);
    check_eq("final_stall_cnt", o_stall_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
